// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and frame constants for the UART TX frame generator
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic STOP_1   = 1'b0;
    localparam logic STOP_2   = 1'b1;

    function automatic logic parity_bit(input logic word_xor, input logic typ);
        return (typ == PAR_ODD) ? ~word_xor : word_xor;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - parallel-load LSB-first shift register with registered word parity
module uart_tx_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  lsb,
    output logic                  parity
);

    logic [DATA_WIDTH-1:0] sr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr     <= '0;
            parity <= 1'b0;
        end else if (load) begin
            sr     <= din;
            parity <= ^din;
        end else if (shift) begin
            sr <= {1'b0, sr[DATA_WIDTH-1:1]};
        end
    end

    assign lsb = sr[0];

endmodule

// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - UART transmit frame FSM: start, data, optional parity, 1 or 2 stop bits
module uart_tx_frame_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  two_stop,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_start,
    output logic                  tx_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    tx_state_e        state;
    logic [CNT_W-1:0] bit_idx;
    logic             par_en_l;
    logic             par_typ_l;
    logic             two_stop_l;
    logic             sh_lsb;
    logic             sh_parity;
    logic             frame_end;
    logic             accept;
    logic             shift_en;

    assign frame_end = baud_tick &&
                       ((state == ST_STOP1 && two_stop_l != STOP_2) || state == ST_STOP2);
    // A word waiting at the final stop tick is taken at once so frames run back-to-back.
    assign accept    = data_valid && (state == ST_IDLE || frame_end);
    assign shift_en  = baud_tick &&
                       (state == ST_START || (state == ST_DATA && bit_idx != LAST_IDX));

    uart_tx_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
        .CLK    (CLK),
        .RST    (RST),
        .load   (accept),
        .shift  (shift_en),
        .din    (p_data),
        .lsb    (sh_lsb),
        .parity (sh_parity)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            tx_out      <= 1'b1;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            tx_done     <= 1'b0;
            par_en_l    <= 1'b0;
            par_typ_l   <= PAR_EVEN;
            two_stop_l  <= STOP_1;
        end else begin
            frame_start <= 1'b0;
            tx_done     <= 1'b0;
            if (accept) begin
                state       <= ST_START;
                bit_idx     <= '0;
                tx_out      <= 1'b0;
                busy        <= 1'b1;
                frame_start <= 1'b1;
                tx_done     <= frame_end;
                par_en_l    <= par_en;
                par_typ_l   <= par_typ;
                two_stop_l  <= two_stop;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                    ST_START: if (baud_tick) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx_out  <= sh_lsb;
                    end
                    ST_DATA: if (baud_tick) begin
                        if (bit_idx == LAST_IDX) begin
                            if (par_en_l) begin
                                state  <= ST_PARITY;
                                tx_out <= parity_bit(sh_parity, par_typ_l);
                            end else begin
                                state  <= ST_STOP1;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + CNT_W'(1);
                            tx_out  <= sh_lsb;
                        end
                    end
                    ST_PARITY: if (baud_tick) begin
                        state  <= ST_STOP1;
                        tx_out <= 1'b1;
                    end
                    ST_STOP1, ST_STOP2: if (baud_tick) begin
                        tx_out <= 1'b1;
                        if (frame_end) begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            state <= ST_STOP2;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        bit_idx <= '0;
                        tx_out  <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
